// File: rtl/mest_pro_pkg.sv
// Shared definitions for the memory arbiter: FSM encoding and requester IDs.
package mest_pro_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDATA  = 2'd2
    } state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: on a tie the requester not granted last wins.
module rr_arbiter2
    import mest_pro_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner
);

    // Tie goes to the requester that was not granted last; otherwise the lone requester.
    always_comb begin
        winner = REQ_CPU;
        if (req == 2'b11) begin
            winner = ~last;
        end else if (req[REQ_DBG]) begin
            winner = REQ_DBG;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU port and a debug/loader port onto one synchronous block RAM.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | sample eligible requests, latch the winner's payload
// ACCESS | drive the RAM from the latched payload, pulse winner's gnt
// RDATA  | RAM read data arrives, pulse winner's rvalid, capture rdata
module mem_arbiter
    import mest_pro_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  cpu_req,
    input  logic                  cpu_wen,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,

    input  logic                  dbg_req,
    input  logic                  dbg_wen,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    input  logic                  dbg_lock,

    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,

    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_t                  state_q;
    state_t                  state_d;
    logic                    owner_q;
    logic                    last_q;
    logic                    wen_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              eligible;
    logic                    winner;
    logic                    select;

    // The CPU drops out of arbitration entirely while the debug port holds the lock.
    assign eligible = {dbg_req, cpu_req & ~dbg_lock};
    assign select   = (state_q == IDLE) && (eligible != 2'b00);

    rr_arbiter2 u_rr (
        .req    (eligible),
        .last   (last_q),
        .winner (winner)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state output pulses.
    always_comb begin
        state_d    = state_q;
        cpu_gnt    = 1'b0;
        dbg_gnt    = 1'b0;
        cpu_rvalid = 1'b0;
        dbg_rvalid = 1'b0;
        mem_wen    = 1'b0;
        rdata      = rdata_q;
        busy       = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (select) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_wen = wen_q;
                cpu_gnt = (owner_q == REQ_CPU);
                dbg_gnt = (owner_q == REQ_DBG);
                state_d = wen_q ? IDLE : RDATA;
            end
            RDATA: begin
                cpu_rvalid = (owner_q == REQ_CPU);
                dbg_rvalid = (owner_q == REQ_DBG);
                rdata      = mem_rdata;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Payload latch at selection, grant history at grant, read-data hold at RDATA.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= REQ_CPU;
            last_q  <= REQ_DBG;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (select) begin
                owner_q <= winner;
                wen_q   <= (winner == REQ_DBG) ? dbg_wen   : cpu_wen;
                addr_q  <= (winner == REQ_DBG) ? dbg_addr  : cpu_addr;
                wdata_q <= (winner == REQ_DBG) ? dbg_wdata : cpu_wdata;
            end
            if (state_q == ACCESS) begin
                last_q <= owner_q;
            end
            if (state_q == RDATA) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural 1-cycle-latency block RAM.
module tb_mem_arbiter;

    localparam int DW = 16;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_wen, cpu_gnt, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          dbg_req, dbg_wen, dbg_gnt, dbg_rvalid, dbg_lock;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_wen    (cpu_wen),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .dbg_req    (dbg_req),
        .dbg_wen    (dbg_wen),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_lock   (dbg_lock),
        .rdata      (rdata),
        .busy       (busy),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Block RAM model: synchronous write, registered read.
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        string         name;
        bit            is_rv;
        bit            id;
        int            at;
        logic [AW-1:0] addr;
        bit            wen;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic push_gnt(input string name, input bit id, input int at,
                            input logic [AW-1:0] addr, input bit wen, input logic [DW-1:0] wd);
        exp_t e;
        e.name = name; e.is_rv = 1'b0; e.id = id; e.at = at;
        e.addr = addr; e.wen = wen; e.data = wd;
        sb.push_back(e);
    endtask

    task automatic push_rv(input string name, input bit id, input int at, input logic [DW-1:0] rd);
        exp_t e;
        e.name = name; e.is_rv = 1'b1; e.id = id; e.at = at;
        e.addr = '0; e.wen = 1'b0; e.data = rd;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h (cyc %0d)", name, got, want, cyc);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},      {31'd0, busy},       32'd0);
        chk({tag, "_cpu_gnt"},   {31'd0, cpu_gnt},    32'd0);
        chk({tag, "_dbg_gnt"},   {31'd0, dbg_gnt},    32'd0);
        chk({tag, "_cpu_rv"},    {31'd0, cpu_rvalid}, 32'd0);
        chk({tag, "_dbg_rv"},    {31'd0, dbg_rvalid}, 32'd0);
        chk({tag, "_mem_wen"},   {31'd0, mem_wen},    32'd0);
        chk({tag, "_mem_addr"},  {24'd0, mem_addr},   32'd0);
        chk({tag, "_mem_wdata"}, {16'd0, mem_wdata},  32'd0);
        chk({tag, "_rdata"},     {16'd0, rdata},      32'd0);
    endtask

    // Advance to #1 after the posedge that brings the cycle count to t.
    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every gnt/rvalid pulse is matched against the head of the scoreboard.
    int   np;
    bit   obs_rv, obs_id, ok;
    exp_t e_m;
    always @(negedge clk) begin
        np = int'(cpu_gnt) + int'(dbg_gnt) + int'(cpu_rvalid) + int'(dbg_rvalid);
        if (np > 1) begin
            n_err++;
            $display("FAIL exclusive_pulses got cg=%b dg=%b cr=%b dr=%b want at most one (cyc %0d)",
                     cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, cyc);
        end
        if (mem_wen && !(cpu_gnt || dbg_gnt)) begin
            n_err++;
            $display("FAIL stray_mem_wen got mem_wen=1 want 0 outside a write grant (cyc %0d)", cyc);
        end
        if (np >= 1) begin
            obs_rv = cpu_rvalid | dbg_rvalid;
            obs_id = dbg_gnt | dbg_rvalid;
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse got rv=%b id=%b at cyc %0d want no pulse",
                         obs_rv, obs_id, cyc);
            end else begin
                e_m = sb.pop_front();
                ok  = (obs_rv == e_m.is_rv) && (obs_id == e_m.id) && (cyc == e_m.at);
                if (!e_m.is_rv) begin
                    ok = ok && (mem_addr === e_m.addr) && (mem_wen === e_m.wen)
                            && (!e_m.wen || (mem_wdata === e_m.data));
                end else begin
                    ok = ok && (rdata === e_m.data);
                end
                if (!ok) begin
                    n_err++;
                    $display("FAIL %s got rv=%b id=%b cyc=%0d addr=%0h wen=%b wd=%0h rd=%0h want rv=%b id=%b cyc=%0d addr=%0h wen=%b data=%0h",
                             e_m.name, obs_rv, obs_id, cyc, mem_addr, mem_wen, mem_wdata, rdata,
                             e_m.is_rv, e_m.id, e_m.at, e_m.addr, e_m.wen, e_m.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want $finish");
        $fatal(1, "watchdog");
    end

    int s;
    int t;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 16'hBEEF;
        mem[8'h30] = 16'hCAFE;
        mem[8'h40] = 16'h5A5A;
        mem_rdata  = '0;

        reset     = 1'b1;
        cpu_req   = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req   = 1'b0; dbg_wen = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        dbg_lock  = 1'b0;

        goto(2);
        reset = 1'b0;
        @(negedge clk);
        chk_idle("rst");

        // CPU-only read of 0x10.
        s = cyc + 1;
        goto(s);
        cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 8'h10; cpu_wdata = '0;
        push_gnt("A_cpu_gnt", 1'b0, s + 1, 8'h10, 1'b0, 16'h0);
        push_rv ("A_cpu_rv",  1'b0, s + 2, 16'hBEEF);
        goto(s + 1);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("A_busy_access", {31'd0, busy}, 32'd1);
        goto(s + 2);
        @(negedge clk);
        chk("A_busy_rdata", {31'd0, busy}, 32'd1);
        goto(s + 3);
        @(negedge clk);
        chk("A_busy_idle", {31'd0, busy}, 32'd0);
        chk("A_rdata_hold", {16'd0, rdata}, 32'h0000BEEF);

        // Debug write 0x20 <- 0x1234, then CPU reads it back.
        s = cyc + 1;
        goto(s);
        dbg_req = 1'b1; dbg_wen = 1'b1; dbg_addr = 8'h20; dbg_wdata = 16'h1234;
        push_gnt("B_dbg_wr_gnt", 1'b1, s + 1, 8'h20, 1'b1, 16'h1234);
        goto(s + 1);
        dbg_req = 1'b0;
        goto(s + 2);
        cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 8'h20;
        push_gnt("B_cpu_gnt", 1'b0, s + 3, 8'h20, 1'b0, 16'h0);
        push_rv ("B_cpu_rv",  1'b0, s + 4, 16'h1234);
        goto(s + 3);
        cpu_req = 1'b0;
        goto(s + 5);

        // Lock raised during a CPU write: write completes, CPU excluded next.
        s = cyc + 1;
        goto(s);
        cpu_req = 1'b1; cpu_wen = 1'b1; cpu_addr = 8'h50; cpu_wdata = 16'h00AA;
        push_gnt("E_cpu_wr_gnt", 1'b0, s + 1, 8'h50, 1'b1, 16'h00AA);
        goto(s + 1);
        dbg_lock = 1'b1;
        dbg_req = 1'b1; dbg_wen = 1'b0; dbg_addr = 8'h50; dbg_wdata = '0;
        push_gnt("E_dbg_gnt", 1'b1, s + 3, 8'h50, 1'b0, 16'h0);
        push_rv ("E_dbg_rv",  1'b1, s + 4, 16'h00AA);
        goto(s + 3);
        cpu_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0;
        cpu_wen = 1'b0; cpu_wdata = '0;
        goto(s + 5);

        // Reset, then both read continuously: CPU, DBG, CPU, DBG every 3 cycles.
        t = cyc + 1;
        goto(t);
        reset = 1'b1;
        goto(t + 2);
        reset = 1'b0;
        s = t + 2;
        cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 8'h10;
        dbg_req = 1'b1; dbg_wen = 1'b0; dbg_addr = 8'h30;
        push_gnt("C_cpu_gnt0", 1'b0, s + 1,  8'h10, 1'b0, 16'h0);
        push_rv ("C_cpu_rv0",  1'b0, s + 2,  16'hBEEF);
        push_gnt("C_dbg_gnt0", 1'b1, s + 4,  8'h30, 1'b0, 16'h0);
        push_rv ("C_dbg_rv0",  1'b1, s + 5,  16'hCAFE);
        push_gnt("C_cpu_gnt1", 1'b0, s + 7,  8'h10, 1'b0, 16'h0);
        push_rv ("C_cpu_rv1",  1'b0, s + 8,  16'hBEEF);
        push_gnt("C_dbg_gnt1", 1'b1, s + 10, 8'h30, 1'b0, 16'h0);
        push_rv ("C_dbg_rv1",  1'b1, s + 11, 16'hCAFE);
        @(negedge clk);
        chk_idle("rst2");
        goto(s + 10);
        cpu_req = 1'b0; dbg_req = 1'b0;
        goto(s + 12);

        // Lock held: four debug reads only; lock released -> CPU next, then DBG.
        s = cyc + 1;
        goto(s);
        dbg_lock = 1'b1;
        cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 8'h10;
        dbg_req = 1'b1; dbg_wen = 1'b0; dbg_addr = 8'h40;
        for (int k = 0; k < 4; k++) begin
            push_gnt($sformatf("D_dbg_gnt%0d", k), 1'b1, s + 1 + 3 * k, 8'h40, 1'b0, 16'h0);
            push_rv ($sformatf("D_dbg_rv%0d", k),  1'b1, s + 2 + 3 * k, 16'h5A5A);
        end
        goto(s + 10);
        dbg_lock = 1'b0;
        push_gnt("D_cpu_gnt", 1'b0, s + 13, 8'h10, 1'b0, 16'h0);
        push_rv ("D_cpu_rv",  1'b0, s + 14, 16'hBEEF);
        goto(s + 13);
        cpu_req = 1'b0;
        push_gnt("D_dbg_gnt4", 1'b1, s + 16, 8'h40, 1'b0, 16'h0);
        push_rv ("D_dbg_rv4",  1'b1, s + 17, 16'h5A5A);
        goto(s + 16);
        dbg_req = 1'b0;
        goto(s + 19);

        // Reset during the ACCESS cycle of a read: grant seen, no rvalid afterwards.
        s = cyc + 1;
        goto(s);
        cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 8'h10;
        push_gnt("F_cpu_gnt", 1'b0, s + 1, 8'h10, 1'b0, 16'h0);
        goto(s + 1);
        reset = 1'b1;
        goto(s + 2);
        reset = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        chk_idle("midrst");
        goto(s + 6);

        chk("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
